// File: rtl/opb_status_slv_mux_pkg.sv
// Shared types and constants for the OPB status-register slave multiplexer.
package opb_status_slv_mux_pkg;

    localparam int OPB_DWIDTH = 32;

    typedef enum logic [1:0] {
        IDLE,
        FWD,
        RESP,
        DONE
    } state_e;

    typedef enum logic [1:0] {
        ACK,
        ERR,
        RETRY
    } resp_e;

endpackage

// File: rtl/opb_status_slv_mux_if.sv
// OPB-side and downstream-slave-side signals of the status slave multiplexer.
interface opb_status_slv_mux_if #(
    parameter int NUM_SLAVES = 8
);
    logic [0:31]                 OPB_ABus;
    logic [0:31]                 OPB_DBus;
    logic [0:3]                  OPB_BE;
    logic                        OPB_RNW;
    logic                        OPB_select;
    logic                        OPB_seqAddr;

    logic [0:31]                 Sl_DBus;
    logic                        Sl_xferAck;
    logic                        Sl_errAck;
    logic                        Sl_retry;
    logic                        Sl_toutSup;

    logic [NUM_SLAVES-1:0]       S_select;
    logic [32*NUM_SLAVES-1:0]    S_DBus;
    logic [NUM_SLAVES-1:0]       S_xferAck;
    logic [NUM_SLAVES-1:0]       S_errAck;
    logic [NUM_SLAVES-1:0]       S_retry;

    logic [7:0]                  timeout_cnt;

    modport slave (
        input  OPB_ABus, OPB_DBus, OPB_BE, OPB_RNW, OPB_select, OPB_seqAddr,
        input  S_DBus, S_xferAck, S_errAck, S_retry,
        output Sl_DBus, Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup,
        output S_select, timeout_cnt
    );

    modport master (
        output OPB_ABus, OPB_DBus, OPB_BE, OPB_RNW, OPB_select, OPB_seqAddr,
        output S_DBus, S_xferAck, S_errAck, S_retry,
        input  Sl_DBus, Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup,
        input  S_select, timeout_cnt
    );
endinterface

// File: rtl/opb_status_slv_mux_wdog.sv
// Watchdog for the FWD state plus a saturating count of expiries.
module opb_status_slv_mux_wdog #(
    parameter int C_TIMEOUT = 12
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_fwd,
    input  logic       hold,
    output logic       expire,
    output logic [7:0] timeout_cnt
);
    localparam int CW = $clog2(C_TIMEOUT + 1);

    logic [CW-1:0] cnt;

    // A handshake or an abort in the final cycle takes precedence over the expiry.
    assign expire = in_fwd && !hold && (cnt == CW'(C_TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt         <= '0;
            timeout_cnt <= '0;
        end else begin
            cnt <= in_fwd ? cnt + 1'b1 : '0;
            if (expire && timeout_cnt != 8'hFF)
                timeout_cnt <= timeout_cnt + 8'd1;
        end
    end

endmodule

// File: rtl/opb_status_slv_mux.sv
// Shares one OPB address region among up to 16 register slaves.
// Optional watchdog: define OPB_STATUS_SLV_MUX_WATCHDOG_EN.
module opb_status_slv_mux
    import opb_status_slv_mux_pkg::*;
#(
    parameter logic [31:0] C_BASEADDR   = 32'h0108_0000,
    parameter int          C_NUM_SLAVES = 8,
    parameter int          C_SPAN_LOG2  = 8,
    parameter int          C_TIMEOUT    = 12
) (
    input logic                 OPB_Clk,
    input logic                 OPB_Rst_n,
    opb_status_slv_mux_if.slave bus
);
    localparam int IW = (C_NUM_SLAVES > 1) ? $clog2(C_NUM_SLAVES) : 1;

    state_e                  state;
    logic [IW-1:0]           idx_r;
    logic                    tout_sup_r;

    logic [31:0]             offset;
    logic [31:0]             idx_full;
    logic                    hit;
    logic [C_NUM_SLAVES-1:0] hit_sel;
    logic                    sel_ack;
    logic                    sel_err;
    logic                    sel_retry;
    logic [0:OPB_DWIDTH-1]   sel_data;
    logic                    hs_any;
    logic                    abort;
    logic                    expire;
    resp_e                   kind;

    // NOTE: every always_comb output gets a default before any branch, so no latch is inferred.
    always_comb begin
        offset    = bus.OPB_ABus - C_BASEADDR;
        idx_full  = offset >> C_SPAN_LOG2;
        hit       = bus.OPB_select && (bus.OPB_ABus >= C_BASEADDR)
                    && (idx_full < 32'(C_NUM_SLAVES));
        hit_sel   = '0;
        sel_ack   = 1'b0;
        sel_err   = 1'b0;
        sel_retry = 1'b0;
        sel_data  = '0;
        for (int i = 0; i < C_NUM_SLAVES; i++) begin
            hit_sel[i] = (idx_full == 32'(i));
            if (idx_r == IW'(i)) begin
                sel_ack   = bus.S_xferAck[i];
                sel_err   = bus.S_errAck[i];
                sel_retry = bus.S_retry[i];
                sel_data  = bus.S_DBus[OPB_DWIDTH*i +: OPB_DWIDTH];
            end
        end
        hs_any = sel_ack || sel_err || sel_retry;
        abort  = !bus.OPB_select;
        if (sel_err || expire)
            kind = ERR;
        else if (sel_ack)
            kind = ACK;
        else
            kind = RETRY;
    end

`ifdef OPB_STATUS_SLV_MUX_WATCHDOG_EN
    opb_status_slv_mux_wdog #(
        .C_TIMEOUT (C_TIMEOUT)
    ) u_wdog (
        .clk         (OPB_Clk),
        .rst_n       (OPB_Rst_n),
        .in_fwd      (state == FWD),
        .hold        (hs_any || abort),
        .expire      (expire),
        .timeout_cnt (bus.timeout_cnt)
    );
`else
    assign expire          = 1'b0;
    assign bus.timeout_cnt = '0;
`endif

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
        if (!OPB_Rst_n) begin
            state          <= IDLE;
            idx_r          <= '0;
            tout_sup_r     <= 1'b0;
            bus.S_select   <= '0;
            bus.Sl_DBus    <= '0;
            bus.Sl_xferAck <= 1'b0;
            bus.Sl_errAck  <= 1'b0;
            bus.Sl_retry   <= 1'b0;
        end else begin
            bus.Sl_DBus    <= '0;
            bus.Sl_xferAck <= 1'b0;
            bus.Sl_errAck  <= 1'b0;
            bus.Sl_retry   <= 1'b0;
            case (state)
                IDLE: begin
                    if (hit) begin
                        idx_r        <= idx_full[IW-1:0];
                        bus.S_select <= hit_sel;
                        tout_sup_r   <= 1'b1;
                        state        <= FWD;
                    end
                end
                FWD: begin
                    if (abort) begin
                        bus.S_select <= '0;
                        tout_sup_r   <= 1'b0;
                        state        <= IDLE;
                    end else if (hs_any || expire) begin
                        bus.S_select   <= '0;
                        bus.Sl_xferAck <= (kind == ACK);
                        bus.Sl_errAck  <= (kind == ERR);
                        bus.Sl_retry   <= (kind == RETRY);
                        // Only a read that completes normally carries data.
                        bus.Sl_DBus    <= (kind == ACK && bus.OPB_RNW) ? sel_data : '0;
                        state          <= RESP;
                    end
                end
                RESP: begin
                    tout_sup_r <= 1'b0;
                    state      <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // The hit-cycle term is combinational; it is gated by reset so outputs stay quiet in reset.
    assign bus.Sl_toutSup = tout_sup_r || (OPB_Rst_n && (state == IDLE) && hit);

    logic unused_ok;
    assign unused_ok = ^{bus.OPB_DBus, bus.OPB_BE, bus.OPB_seqAddr};

endmodule

// File: doc/opb_status_slv_mux.md
# opb_status_slv_mux

Sequencing controller that shares one OPB slave address region among up to 16 software-register slaves, such as the status and overflow registers written from Simulink user logic. It decodes the OPB address, forwards a registered select to exactly one downstream slave, waits for that slave's handshake, and returns one registered response to the OPB. A watchdog, compiled in with a macro, terminates transactions to a slave that does not respond.

## Interface
- C_BASEADDR, 32'h01080000: base of the shared region.
- C_NUM_SLAVES, 8: number of slave windows, range 1..16.
- C_SPAN_LOG2, 8: log2 of the window size in bytes. Slave i occupies BASE + i·2^SPAN to BASE + (i+1)·2^SPAN − 1.
- C_TIMEOUT, 12: watchdog limit, in cycles spent in FWD.
- OPB_Clk  in  1: sole clock.
- OPB_Rst_n  in  1: asynchronous, active-low reset.
- OPB_ABus  in  [0:31]: master address.
- OPB_DBus  in  [0:31]: write data, broadcast unregistered to all slaves.
- OPB_BE  in  [0:3]: byte enables, broadcast.
- OPB_RNW  in  1: read/not-write, broadcast.
- OPB_select  in  1: transaction request.
- OPB_seqAddr  in  1: ignored; each beat is handled as a single transfer.
- Sl_DBus  out  [0:31]: read data. Zero except in the RESP state.
- Sl_xferAck, Sl_errAck, Sl_retry  out  1: single-cycle responses.
- Sl_toutSup  out  1: suppresses the master's own timeout.
- S_select  out  [C_NUM_SLAVES-1:0]: one-hot select to the downstream slaves.
- S_DBus  in  [32·C_NUM_SLAVES-1:0]: slave read data. Slave i occupies bits 32i+31 down to 32i, and bit 32i+31 maps to Sl_DBus[0].
- S_xferAck, S_errAck, S_retry  in  [C_NUM_SLAVES-1:0]: slave handshakes.
- timeout_cnt  out  8: saturating count of watchdog expiries.

## Operation
- The FSM has four states: IDLE, FWD, RESP and DONE. Reset puts the FSM in IDLE, and at reset every output is 0.
- Hit condition:
  - OPB_select=1, and
  - OPB_ABus ≥ C_BASEADDR, and
  - index = (OPB_ABus − C_BASEADDR) >> C_SPAN_LOG2 is less than C_NUM_SLAVES.
- The subtraction is 32-bit unsigned; an underflow counts as a miss.
- IDLE, on a hit: latch the index into idx_r and go to FWD.
- IDLE, on a miss: stay in IDLE with all outputs 0. OPB OR-combines slave outputs, so the block must stay silent.
- FWD:
  - S_select[idx_r]=1.
  - When S_xferAck, S_errAck or S_retry of idx_r is sampled high, latch the data (for reads only; writes latch 0) and latch the kind of response, then go to RESP.
  - Handshake bits from other slaves are ignored.
  - If S_xferAck and S_errAck arrive together, errAck wins. retry has the lowest priority.
- FWD, if OPB_select drops (master abort): go straight to IDLE, deassert S_select and produce no response.
- RESP: drive the latched Sl_DBus and exactly one of Sl_xferAck, Sl_errAck or Sl_retry for one cycle. S_select=0. Then go to DONE.
- DONE: all outputs 0 for one cycle, then IDLE. This keeps a still-high OPB_select from double-issuing a transaction.
- Sl_toutSup=1 in the cycle of a hit, and in FWD and RESP.
- A reset during any state returns the block to IDLE immediately, with outputs 0. timeout_cnt clears to 0.

## Timing
- Define cycle 0 as the cycle in which the hit is sampled in IDLE.
- S_select rises at cycle 1.
- If the slave acks at cycle k (k ≥ 1), Sl_xferAck is high at cycle k+1 only. The earliest complete transfer is therefore 3 cycles from select.
- The next hit can be accepted 2 cycles after RESP, once DONE has returned to IDLE.
- All outputs are registered except Sl_toutSup in the hit cycle, which is combinational from the decode.

## Configuration
- OPB_STATUS_SLV_MUX_WATCHDOG_EN defined:
  - A counter runs in FWD.
  - When it reaches C_TIMEOUT cycles without a slave handshake, the FSM goes to RESP with Sl_errAck=1 and Sl_DBus=0.
  - timeout_cnt increments, saturating at 255.
  - The counter clears on entry to FWD.
- Macro undefined:
  - There is no watchdog, and FWD waits indefinitely while holding Sl_toutSup.
  - timeout_cnt is tied to 0.

## Structure
- Package opb_status_slv_mux_pkg contains:
  - the state enum (IDLE, FWD, RESP, DONE);
  - the response-kind enum (ACK, ERR, RETRY);
  - OPB_DWIDTH=32.
- Sub-module opb_status_slv_mux_wdog contains the watchdog counter and the timeout_cnt saturation logic. It is instantiated only under the macro.

## Test plan
- Read from slave 3 with defaults: ABus=0x01080304 at cycle 0, slave 3 acks at cycle 2 with data 0xDEADBEEF. Required: S_select=0x08 during cycles 1–2, Sl_xferAck and Sl_DBus=0xDEADBEEF at cycle 3, zeros at cycle 4.
- Misses: ABus=0x01080800 (index 8) and ABus=0x0107FFFC. Required: S_select stays 0, and Sl_toutSup and all other outputs stay 0.
- Watchdog (macro on): select slave 0 and never ack. Required: Sl_errAck at cycle 13, timeout_cnt=1. After 300 such timeouts, timeout_cnt=255.
- Priority and isolation: slave 2 asserts S_xferAck and S_errAck in the same cycle while slave 5 asserts S_xferAck. Required: only Sl_errAck, with Sl_DBus=0 (errAck wins, no data latched).
- Abort: OPB_select drops at cycle 2 of FWD. Required: S_select=0 at cycle 3 and no response.
- Reset mid-operation: OPB_Rst_n low during FWD. Required: all outputs 0 asynchronously. After release, the next hit behaves like a cycle-0 hit.
